// File: rtl/psub_seq.sv
// Sequential nibble-serial saturating subtractor: one 16-bit signed subtract or
// four independent 4-bit signed lanes, one nibble per cycle over four RUN cycles.

module psub_lane (
   input  logic       a_s,
   input  logic       b_s,
   input  logic [3:0] raw,
   output logic       ovf,
   output logic [3:0] sat
);
   assign ovf = (a_s != b_s) && (raw[3] != a_s);
   assign sat = ovf ? (a_s ? 4'h8 : 4'h7) : raw;
endmodule

module psub_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] A,
   input  logic [15:0] B,
   input  logic        pad,
   output logic        busy,
   output logic        done,
   output logic [15:0] Diff,
   output logic        Ovfl,
   output logic        Zero,
   output logic        Neg
);
   localparam int NUM_LANES = 4;
   localparam int LANE_W    = 4;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      state;
   logic [1:0]  cnt;
   logic [15:0] a_r, b_r, acc;
   logic        pad_r, carry;

   logic        cin;
   logic [4:0]  nsum;
   logic [15:0] raw, word_res, res;
   logic        word_ovf, res_ovf;
   logic [NUM_LANES-1:0]             lane_ovf;
   logic [NUM_LANES-1:0][LANE_W-1:0] lane_sat;

   // Current nibble merged into the accumulator so the final nibble can be
   // saturated and registered on the same edge it is computed.
   always_comb begin
      cin  = (pad_r || cnt == 2'd0) ? 1'b1 : carry;
      nsum = {1'b0, a_r[{cnt, 2'b00} +: 4]} + {1'b0, ~b_r[{cnt, 2'b00} +: 4]} + {4'b0, cin};
      raw  = acc;
      raw[{cnt, 2'b00} +: 4] = nsum[3:0];
   end

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      psub_lane u_lane (
         .a_s (a_r[LANE_W*g + LANE_W-1]),
         .b_s (b_r[LANE_W*g + LANE_W-1]),
         .raw (raw[LANE_W*g +: LANE_W]),
         .ovf (lane_ovf[g]),
         .sat (lane_sat[g])
      );
   end

   assign word_ovf = (a_r[15] != b_r[15]) && (raw[15] != a_r[15]);
   assign word_res = word_ovf ? (a_r[15] ? 16'h8000 : 16'h7FFF) : raw;
   assign res      = pad_r ? lane_sat : word_res;
   assign res_ovf  = pad_r ? |lane_ovf : word_ovf;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= 2'd0;
         a_r   <= '0;
         b_r   <= '0;
         acc   <= '0;
         pad_r <= 1'b0;
         carry <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
         Diff  <= '0;
         Ovfl  <= 1'b0;
         Zero  <= 1'b0;
         Neg   <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               busy <= start;
               if (start) begin
                  a_r   <= A;
                  b_r   <= B;
                  pad_r <= pad;
                  cnt   <= 2'd0;
                  state <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               acc[{cnt, 2'b00} +: 4] <= nsum[3:0];
               carry <= nsum[4];
               cnt   <= cnt + 2'd1;
               if (cnt == 2'd3) begin
                  Diff  <= res;
                  Ovfl  <= res_ovf;
                  Zero  <= (res == 16'h0000);
                  Neg   <= res[15];
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule
